sliced_compare_unit: RTL

//   Multi-cycle, parametrised successor to the single-cycle flag-based branch compare.

---
 rtl/sliced_compare_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sliced_compare_unit.sv
// Multi-cycle branch compare: walks operand A against B (or zero) one SLICE-bit
// slice per cycle, MSB slice first, with valid/ready handshakes on both sides.
module sliced_compare_unit #(
  parameter int WIDTH      = 32,
  parameter int SLICE      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_ft,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic             out_illegal,
  output logic [1:0]       dbg_state
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("sliced_compare_unit: WIDTH must be a multiple of SLICE");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // The requester holds in_valid/in_a/in_b/in_ft until accepted; out_s/out_illegal stay
  // stable while out_valid is high and out_ready is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] FT_NEQ = 3'b000;
  localparam logic [2:0] FT_EQ  = 3'b001;
  localparam logic [2:0] FT_LT  = 3'b010;
  localparam logic [2:0] FT_LTU = 3'b011;
  localparam logic [2:0] FT_GEZ = 3'b100;
  localparam logic [2:0] FT_RSV = 3'b101;
  localparam logic [2:0] FT_LEZ = 3'b110;
  localparam logic [2:0] FT_GTZ = 3'b111;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ft_q;
  logic [IDXW-1:0]  idx;
  logic             decided;
  logic             lt;

  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] sa_k;
  logic [SLICE-1:0] sb_k;
  logic             msb_signed;
  logic             diff;
  logic             dec_n;
  logic             lt_n;
  logic             last;
  logic             res;

  // Operands shift left each BUSY cycle, so the current slice is always the top one.
  assign sa = a_q[WIDTH-1 -: SLICE];
  assign sb = b_q[WIDTH-1 -: SLICE];

  // Flipping the sign bit of the MSB slice turns two's-complement order into unsigned order.
  assign msb_signed = (idx == '0) && (ft_q != FT_LTU);
  assign sa_k       = sa ^ (SLICE'(msb_signed) << (SLICE - 1));
  assign sb_k       = sb ^ (SLICE'(msb_signed) << (SLICE - 1));

  assign diff  = (sa != sb);
  assign dec_n = decided | diff;
  assign lt_n  = decided ? lt : (diff & (sa_k < sb_k));
  assign last  = (idx == IDXW'(NSLICE - 1)) || ((EARLY_EXIT != 0) && diff);

  always_comb begin
    res = 1'b0;
    case (ft_q)
      FT_NEQ:        res = dec_n;
      FT_EQ:         res = !dec_n;
      FT_LT, FT_LTU: res = lt_n;
      FT_GEZ:        res = !lt_n;
      FT_LEZ:        res = lt_n | !dec_n;
      FT_GTZ:        res = !lt_n & dec_n;
      default:       res = 1'b0;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ft_q        <= '0;
      idx         <= '0;
      decided     <= 1'b0;
      lt          <= 1'b0;
      out_valid   <= 1'b0;
      out_s       <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_ft[2] ? '0 : in_b;
            ft_q    <= in_ft;
            idx     <= '0;
            decided <= 1'b0;
            lt      <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          decided <= dec_n;
          lt      <= lt_n;
          a_q     <= a_q << SLICE;
          b_q     <= b_q << SLICE;
          if (last) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            out_s       <= res;
            out_illegal <= (ft_q == FT_RSV);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
